// File: rtl/sram_like_responder_pkg.sv
// Shared definitions for the SRAM-like responder: size encodings and the
// response-stage record carried down the latency line.
package sram_like_responder_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int RESP_W = 1 + 1 + 32;

    typedef struct packed {
        logic        valid;
        logic        wr;
        logic [31:0] data;
    } resp_t;

    // Reads never touch RAM byte lanes, whatever the master put on wstrb.
    function automatic logic [3:0] lane_we(input logic wr, input logic [3:0] wstrb);
        return wr ? wstrb : 4'b0000;
    endfunction

endpackage

// File: rtl/sram_like_responder_if.sv
// SRAM-like request/response bus plus the single-port RAM port behind it.
interface sram_like_responder_if
    import sram_like_responder_pkg::*;
#(
    parameter int ADDR_W = 14
);
    logic              sram_req;
    logic              sram_wr;
    logic [1:0]        sram_size;
    logic [3:0]        sram_wstrb;
    logic [31:0]       sram_addr;
    logic [31:0]       sram_wdata;
    logic              sram_addr_ok;
    logic              sram_data_ok;
    logic [31:0]       sram_rdata;

    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport master (
        output sram_req, sram_wr, sram_size, sram_wstrb, sram_addr, sram_wdata,
        input  sram_addr_ok, sram_data_ok, sram_rdata
    );

    modport slave (
        input  sram_req, sram_wr, sram_size, sram_wstrb, sram_addr, sram_wdata,
        output sram_addr_ok, sram_data_ok, sram_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport mem (
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/sram_like_responder_resp_delay.sv
// EXTRA_LAT-stage shift register of {valid, wr, data} trailing the RAM read;
// with EXTRA_LAT = 0 it is a plain wire.
module sram_resp_delay
    import sram_like_responder_pkg::*;
#(
    parameter int EXTRA_LAT = 0
) (
    input  logic  clk,
    input  logic  rstn,
    input  resp_t resp_i,
    output resp_t resp_o
);

    generate
        if (EXTRA_LAT == 0) begin : g_bypass
            logic unused_s;
            assign unused_s = clk ^ rstn;
            assign resp_o   = resp_i;
        end else begin : g_pipe
            resp_t stage_q [EXTRA_LAT];

            // Shift the response record one stage per cycle; reset empties the line.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int i = 0; i < EXTRA_LAT; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= resp_i;
                    for (int i = 1; i < EXTRA_LAT; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign resp_o = stage_q[EXTRA_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/sram_like_responder.sv
// Responder end of the SRAM-like bus: accepts requests into a single-port RAM
// and answers them in order at a fixed latency of 1 + EXTRA_LAT cycles.
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int EXTRA_LAT = 0,
    parameter int MAX_OUTST = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   stall_i,
    sram_like_responder_if.slave   bus
);

    localparam int             CNT_W   = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

    logic             accept_s;
    logic             s0_valid_q;
    logic             s0_wr_q;
    logic [CNT_W-1:0] outst_cnt_q;
    logic [CNT_W-1:0] outst_cnt_d;
    resp_t            s0_resp_s;
    resp_t            last_resp_s;
    logic             unused_s;

    // Only the registered count gates acceptance, so a retiring response frees its slot next cycle.
    assign accept_s = bus.sram_req & ~stall_i & (outst_cnt_q < CNT_MAX);

    assign bus.sram_addr_ok = accept_s;
    assign bus.ram_en       = accept_s;
    assign bus.ram_we       = accept_s ? lane_we(bus.sram_wr, bus.sram_wstrb) : 4'b0000;
    assign bus.ram_addr     = bus.sram_addr[ADDR_W+1:2];
    assign bus.ram_wdata    = bus.sram_wdata;

    assign unused_s = ^{bus.sram_size, bus.sram_addr[1:0], bus.sram_addr[31:ADDR_W+2]};

    // Stage 0 mirrors the RAM's one-cycle read latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s0_valid_q  <= 1'b0;
            s0_wr_q     <= 1'b0;
            outst_cnt_q <= '0;
        end else begin
            s0_valid_q  <= accept_s;
            s0_wr_q     <= bus.sram_wr;
            outst_cnt_q <= outst_cnt_d;
        end
    end

    // Outstanding count: one accept and/or one retire per cycle.
    always_comb begin
        outst_cnt_d = outst_cnt_q;
        case ({accept_s, last_resp_s.valid})
            2'b10:   outst_cnt_d = outst_cnt_q + CNT_W'(1);
            2'b01:   outst_cnt_d = outst_cnt_q - CNT_W'(1);
            default: outst_cnt_d = outst_cnt_q;
        endcase
    end

    // Writes and empty slots carry zero data down the line.
    always_comb begin
        s0_resp_s.valid = s0_valid_q;
        s0_resp_s.wr    = s0_wr_q;
        if (s0_valid_q && !s0_wr_q) begin
            s0_resp_s.data = bus.ram_rdata;
        end else begin
            s0_resp_s.data = 32'h0000_0000;
        end
    end

    sram_resp_delay #(
        .EXTRA_LAT (EXTRA_LAT)
    ) u_resp_delay (
        .clk    (clk),
        .rstn   (rstn),
        .resp_i (s0_resp_s),
        .resp_o (last_resp_s)
    );

    assign bus.sram_data_ok = last_resp_s.valid;
    assign bus.sram_rdata   = last_resp_s.data;

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench: one responder with LAT=1/MAX=2 and one with LAT=4/MAX=4,
// each backed by a small behavioural RAM.
module tb_sram_like_responder;
    import sram_like_responder_pkg::*;

    localparam int AW = 6;
    localparam int NV = 11;

    logic clk     = 1'b0;
    logic rstn    = 1'b1;
    logic stall_a = 1'b0;
    logic stall_b = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_like_responder_if #(.ADDR_W(AW)) bus_a ();
    sram_like_responder_if #(.ADDR_W(AW)) bus_b ();

    sram_like_responder #(.ADDR_W(AW), .EXTRA_LAT(0), .MAX_OUTST(2)) u_a (
        .clk(clk), .rstn(rstn), .stall_i(stall_a), .bus(bus_a)
    );
    sram_like_responder #(.ADDR_W(AW), .EXTRA_LAT(3), .MAX_OUTST(4)) u_b (
        .clk(clk), .rstn(rstn), .stall_i(stall_b), .bus(bus_b)
    );

    logic [31:0] mem_a [2**AW];
    logic [31:0] mem_b [2**AW];

    // Behavioural single-port RAMs, read-before-write, one-cycle read latency.
    always @(posedge clk) begin
        if (bus_a.ram_en) begin
            bus_a.ram_rdata <= mem_a[bus_a.ram_addr];
            for (int b = 0; b < 4; b++)
                if (bus_a.ram_we[b]) mem_a[bus_a.ram_addr][8*b +: 8] <= bus_a.ram_wdata[8*b +: 8];
        end
        if (bus_b.ram_en) begin
            bus_b.ram_rdata <= mem_b[bus_b.ram_addr];
            for (int b = 0; b < 4; b++)
                if (bus_b.ram_we[b]) mem_b[bus_b.ram_addr][8*b +: 8] <= bus_b.ram_wdata[8*b +: 8];
        end
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic req, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
        bus_a.sram_req   = req;
        bus_a.sram_wr    = wr;
        bus_a.sram_size  = SIZE_W;
        bus_a.sram_addr  = addr;
        bus_a.sram_wdata = wdata;
        bus_a.sram_wstrb = wstrb;
    endtask

    task automatic drive_b(input logic req, input logic [31:0] addr);
        bus_b.sram_req   = req;
        bus_b.sram_wr    = 1'b0;
        bus_b.sram_size  = SIZE_W;
        bus_b.sram_addr  = addr;
        bus_b.sram_wdata = 32'h0;
        bus_b.sram_wstrb = 4'h0;
    endtask

    initial begin
        logic [13:0] lim_acc;
        logic [13:0] lim_dok;
        logic [AW-1:0] exp_ra;
        logic        exp_dok;

        lim_acc = 14'b00000111101111;
        lim_dok = 14'b01111011110000;

        vecs[0]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'h5, 32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hAA22_CC44};
        vecs[3]  = '{1'b0, 32'h0000_0023, 32'h0,         4'h0, 32'hAA22_CC44};
        vecs[4]  = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 4'h0, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 32'h1000_0003};
        vecs[6]  = '{1'b1, 32'h0000_0014, 32'hCAFE_F00D, 4'hF, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 32'hCAFE_F00D};
        vecs[8]  = '{1'b1, 32'h0000_0018, 32'h1234_5678, 4'h8, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0018, 32'h0,         4'h0, 32'h1200_0006};
        vecs[10] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 32'h1000_0000};

        for (int i = 0; i < 2**AW; i++) begin
            mem_a[i] <= 32'h1000_0000 + 32'(i);
            mem_b[i] <= 32'hB000_0000 + 32'(i);
        end
        #1;
        mem_a[16] <= 32'hDEAD_BEEF;
        mem_a[8]  <= 32'hAABB_CCDD;
        drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_b(1'b0, 32'h0);

        // Reset state
        #1 rstn = 1'b0;
        #2;
        check("rst_a_addr_ok", {31'd0, bus_a.sram_addr_ok}, 32'd0);
        check("rst_a_data_ok", {31'd0, bus_a.sram_data_ok}, 32'd0);
        check("rst_a_rdata",   bus_a.sram_rdata,            32'd0);
        check("rst_b_data_ok", {31'd0, bus_b.sram_data_ok}, 32'd0);
        check("rst_b_rdata",   bus_b.sram_rdata,            32'd0);
        check("rst_b_cnt",     32'(u_b.outst_cnt_q),        32'd0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Table: back-to-back requests on the LAT=1 responder
        for (int i = 0; i <= NV; i++) begin
            step();
            if (i < NV) drive_a(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            else        drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            #3;
            if (i < NV) begin
                exp_ra = vecs[i].addr[AW+1:2];
                check("vec_addr_ok", {31'd0, bus_a.sram_addr_ok}, 32'd1);
                check("vec_ram_en",  {31'd0, bus_a.ram_en},       32'd1);
                check("vec_ram_addr", 32'(bus_a.ram_addr),        32'(exp_ra));
                check("vec_ram_we",  {28'd0, bus_a.ram_we},
                      {28'd0, (vecs[i].wr ? vecs[i].wstrb : 4'h0)});
            end
            if (i > 0) begin
                check("vec_data_ok", {31'd0, bus_a.sram_data_ok}, 32'd1);
                check("vec_rdata",   bus_a.sram_rdata,            vecs[i-1].rdata);
            end else begin
                check("vec_no_early_ok", {31'd0, bus_a.sram_data_ok}, 32'd0);
            end
        end
        step();
        #3 check("a_no_repeat", {31'd0, bus_a.sram_data_ok}, 32'd0);

        // Stall with a response already in flight
        step();
        drive_a(1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'h0);
        #3 check("stall_pre_accept", {31'd0, bus_a.sram_addr_ok}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            stall_a = 1'b1;
            drive_a(1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0);
            #3;
            check("stall_addr_ok", {31'd0, bus_a.sram_addr_ok}, 32'd0);
            check("stall_ram_en",  {31'd0, bus_a.ram_en},       32'd0);
            check("stall_data_ok", {31'd0, bus_a.sram_data_ok}, (k == 0) ? 32'd1 : 32'd0);
            if (k == 0) check("stall_rdata", bus_a.sram_rdata, 32'h1000_0001);
        end
        step();
        stall_a = 1'b0;
        drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // LAT=4 ordering: three consecutive reads
        for (int i = 0; i < 10; i++) begin
            step();
            if (i < 3) drive_b(1'b1, 32'(4 * i));
            else       drive_b(1'b0, 32'h0);
            #3;
            if (i < 3) check("ord_addr_ok", {31'd0, bus_b.sram_addr_ok}, 32'd1);
            exp_dok = (i >= 4) && (i <= 6);
            check("ord_data_ok", {31'd0, bus_b.sram_data_ok}, {31'd0, exp_dok});
            if (exp_dok) check("ord_rdata", bus_b.sram_rdata, 32'hB000_0000 + 32'(i - 4));
        end

        // Outstanding limit with req held high
        for (int i = 0; i < 14; i++) begin
            step();
            drive_b((i < 10), 32'h0000_0010);
            #3;
            check("lim_addr_ok", {31'd0, bus_b.sram_addr_ok}, {31'd0, lim_acc[i]});
            check("lim_data_ok", {31'd0, bus_b.sram_data_ok}, {31'd0, lim_dok[i]});
            if (lim_dok[i]) check("lim_rdata", bus_b.sram_rdata, 32'hB000_0004);
            check("lim_cnt_le_max", {31'd0, (u_b.outst_cnt_q <= 3'd4)}, 32'd1);
        end

        // Reset with a read in flight drops its response
        step();
        drive_b(1'b1, 32'h0000_0008);
        #3 check("rstf_accept", {31'd0, bus_b.sram_addr_ok}, 32'd1);
        step();
        drive_b(1'b0, 32'h0);
        #1 rstn = 1'b0;
        #1;
        check("rstf_data_ok", {31'd0, bus_b.sram_data_ok}, 32'd0);
        check("rstf_cnt",     32'(u_b.outst_cnt_q),        32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            #3 check("rstf_no_resp", {31'd0, bus_b.sram_data_ok}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_like_responder.md
Name: sram_like_responder

Overview:
- Responder (slave) end of the SRAM-like req/addr_ok/data_ok interface driven by the fetch and memory stages.
- Accepts requests, drives a synchronous single-port block RAM (1-cycle read latency), and returns in-order responses at a fixed, parameterised latency.
- Used as the on-chip instruction or data memory behind the CPU.
- Doubles as the bench memory model, with an injectable addr_ok stall.

Parameters:
- ADDR_W, 14, word-address width of the RAM (RAM depth = 2^ADDR_W words).
- EXTRA_LAT, 0, extra cycles added after the RAM read; total response latency LAT = 1 + EXTRA_LAT (range 0..7).
- MAX_OUTST, 2, maximum accepted-but-unanswered requests (1..8).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset. Asynchronous, active-low.
- sram_req  in  1  master request valid.
- sram_wr  in  1  1 = write, 0 = read.
- sram_size  in  2  0 = byte, 1 = half, 2 = word (informational; byte lanes come from wstrb).
- sram_wstrb  in  4  write byte enables.
- sram_addr  in  32  byte address; bits [ADDR_W+1:2] index the RAM.
- sram_wdata  in  32  write data.
- sram_addr_ok  out  1  request accepted this cycle.
- sram_data_ok  out  1  one-cycle response pulse.
- sram_rdata  out  32  read data, valid while data_ok = 1.
- stall_i  in  1  forces addr_ok = 0 (bench backpressure; tie to 0 in the CPU).
- ram_en  out  1  RAM port enable.
- ram_we  out  4  RAM byte write enables.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid 1 cycle after ram_en.

Behaviour:
- Reset values: addr_ok = 0, data_ok = 0, rdata = 0, outstanding counter = 0, all delay-line valid bits = 0.
- Reset mid-operation drops every in-flight response; no data_ok is issued for those requests after reset is released.
- Acceptance is combinational: addr_ok = req & !stall_i & (outst_cnt < MAX_OUTST).
  - The accept test uses the registered count only. A response retiring in the same cycle does not free a slot until the next cycle.
- On accept, in the same cycle:
  - ram_en = 1
  - ram_addr = sram_addr[ADDR_W+1:2]
  - ram_we = wr ? wstrb : 4'b0
  - ram_wdata = sram_wdata
- When not accepting, ram_en = 0 and ram_we = 0.
- Response path:
  - Stage 0 is the registered valid, set 1 cycle after accept; rdata is captured from ram_rdata.
  - Then EXTRA_LAT register stages, each holding {valid, wr, data}.
  - data_ok = valid bit of the last stage. The response for a request accepted in cycle N pulses in cycle N + LAT exactly.
- Writes also get a data_ok. Write response rdata = 0. A write with wstrb = 0 is a no-op but still gets a response.
- Responses are strictly in acceptance order. Back-to-back accepts give back-to-back data_ok pulses.
- The master must not backpressure data_ok; a response is never held or repeated.
- outst_cnt update, one per cycle:
  - accept & !data_ok: +1
  - data_ok & !accept: -1
  - both together: unchanged
  - The counter never exceeds MAX_OUTST and never underflows.
- Read-after-write to the same word: a later read returns the new data (RAM is write-first or the reads are ordered by the port). No bypass logic is required because the RAM is single-port.
- Misaligned addresses and size/wstrb consistency are not checked (checks belong to the master's ADE logic); addr[1:0] is ignored.
- stall_i is sampled combinationally and does not affect in-flight responses.

Decomposition:
- Shared package / Defines.vh:
  - SRAM size encodings (SIZE_B/H/W).
  - Response-stage bus width macro (1 + 1 + 32).
- One natural sub-module: sram_resp_delay, a parameterised EXTRA_LAT-stage shift register of {valid, wr, data} with async reset. It is instantiated once.
- Counter, accept logic and RAM drive stay in the top module.

Test Plan:
- Single read: RAM[0x10] = 0xDEADBEEF, EXTRA_LAT = 0, req/read addr 0x40 at cycle 5 → addr_ok = 1 at cycle 5; ram_en = 1 with ram_addr = 0x10 at cycle 5; data_ok = 1 with rdata = 0xDEADBEEF at cycle 6 only.
- Latency/ordering: EXTRA_LAT = 3, MAX_OUTST = 4, reads at 0x0, 0x4, 0x8 on consecutive cycles 10-12 → data_ok pulses at cycles 14, 15, 16 with the matching data.
- Outstanding limit: MAX_OUTST = 2, EXTRA_LAT = 2, req held high → addr_ok pattern 1, 1, 0, 0, then 1 in the cycle after the first data_ok; the count never exceeds 2.
- Write then read: write addr 0x20, wdata 0x11223344, wstrb 0b0101, old word 0xAABBCCDD; then read 0x20 → write data_ok with rdata = 0; read returns 0xAA22CC44.
- Stall: stall_i = 1 for 5 cycles with req = 1 → addr_ok = 0 and ram_en = 0 throughout; a pending response still pulses data_ok on time.
- Reset mid-flight: EXTRA_LAT = 3, accept at cycle 20, rstn low at cycle 21 (async) → data_ok = 0 and outst_cnt = 0 immediately; no data_ok after release.
